// File: rtl/mac_address_cam_table_if.sv
// Request/response bundle between the switch orchestrator and the MAC learning table.
// Master side (orchestrator) drives lookup/learn/delete requests; slave side (table) returns results.
// Signals: match_valid, key, write_valid, write_port, delete_key -> table;
//          match_enable, no_match, match_index, entry_count, table_full <- table.
interface mac_address_cam_table_if #(
  parameter int NUMBER_OF_PORTS = 2,
  parameter int TABLE_DEPTH     = 32
);
  localparam int PW = (NUMBER_OF_PORTS > 2) ? $clog2(NUMBER_OF_PORTS) : 1;
  localparam int IW = $clog2(TABLE_DEPTH);

  logic          match_valid;
  logic [47:0]   key;
  logic          write_valid;
  logic [PW-1:0] write_port;
  logic          delete_key;
  logic          match_enable;
  logic          no_match;
  logic [PW-1:0] match_index;
  logic [IW:0]   entry_count;
  logic          table_full;

  modport master (
    output match_valid, key, write_valid, write_port, delete_key,
    input  match_enable, no_match, match_index, entry_count, table_full
  );

  modport slave (
    input  match_valid, key, write_valid, write_port, delete_key,
    output match_enable, no_match, match_index, entry_count, table_full
  );
endinterface

// File: rtl/mac_address_cam_table.sv
// MAC learning CAM: parallel key compare for lookup/delete/learn, victim replacement, periodic aging.
// Latency: lookup result registered one cycle after match_valid; table updates visible next cycle.
// Backpressure: none, every request is accepted in the cycle it is presented.
// Ports: clock, reset_n (async, active-low), bus (slave side of mac_address_cam_table_if).
module mac_address_cam_table #(
  parameter int          NUMBER_OF_PORTS = 2,
  parameter int          TABLE_DEPTH     = 32,
  parameter logic [31:0] AGING_PERIOD    = 32'd1_000_000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  mac_address_cam_table_if.slave       bus
);
  localparam int PW = (NUMBER_OF_PORTS > 2) ? $clog2(NUMBER_OF_PORTS) : 1;
  localparam int IW = $clog2(TABLE_DEPTH);

  logic [TABLE_DEPTH-1:0] valid_q, valid_d;
  logic [TABLE_DEPTH-1:0] hit_q, hit_d;
  logic [47:0]            mac_q  [TABLE_DEPTH];
  logic [47:0]            mac_d  [TABLE_DEPTH];
  logic [PW-1:0]          port_q [TABLE_DEPTH];
  logic [PW-1:0]          port_d [TABLE_DEPTH];
  logic [IW-1:0]          victim_q, victim_d;
  logic [31:0]            age_cnt_q, age_cnt_d;
  logic                   match_enable_q, match_enable_d;
  logic                   no_match_q, no_match_d;
  logic [PW-1:0]          match_index_q, match_index_d;
  logic [IW:0]            entry_count_q, entry_count_d;
  logic                   table_full_q, table_full_d;

  logic [TABLE_DEPTH-1:0] match_vec;
  logic [IW-1:0]          hit_idx;
  logic [IW-1:0]          free_idx;
  logic [IW-1:0]          wr_idx;
  logic                   present;
  logic                   full;
  logic                   write_ok;
  logic                   age_tick;

  // Lookup, delete and write share one key bus, so a single compare vector
  // (against pre-cycle contents) serves all three request types.
  always_comb begin
    match_vec = '0;
    hit_idx   = '0;
    free_idx  = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (mac_q[i] == bus.key);
      if (match_vec[i]) hit_idx = IW'(i);
    end
    // Scan downward so the lowest free index is the one that sticks.
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

  assign present  = |match_vec;
  assign full     = &valid_q;
  assign write_ok = bus.write_valid && ({{(32-PW){1'b0}}, bus.write_port} < NUMBER_OF_PORTS);
  assign wr_idx   = present ? hit_idx : (full ? victim_q : free_idx);
  assign age_tick = (age_cnt_q == AGING_PERIOD - 32'd1);

  always_comb begin
    logic [IW:0] cnt;
    valid_d   = valid_q;
    hit_d     = hit_q;
    mac_d     = mac_q;
    port_d    = port_q;
    victim_d  = victim_q;
    age_cnt_d = age_tick ? 32'd0 : age_cnt_q + 32'd1;

    // Aging first, so that a same-cycle refresh below can rescue the touched entry.
    if (age_tick) begin
      valid_d = valid_q & hit_q;
      hit_d   = '0;
    end
    if (bus.match_valid && present) begin
      valid_d[hit_idx] = 1'b1;
      hit_d[hit_idx]   = 1'b1;
    end
    if (bus.delete_key && present) begin
      valid_d[hit_idx] = 1'b0;
      hit_d[hit_idx]   = 1'b0;
    end
    // Write applies last: a delete+write of the same key leaves the entry valid.
    if (write_ok) begin
      valid_d[wr_idx] = 1'b1;
      hit_d[wr_idx]   = 1'b1;
      mac_d[wr_idx]   = bus.key;
      port_d[wr_idx]  = bus.write_port;
      if (!present && full) victim_d = victim_q + 1'b1;
    end

    cnt = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) cnt = cnt + (IW+1)'(valid_d[i]);
    entry_count_d = cnt;
    table_full_d  = (cnt == (IW+1)'(TABLE_DEPTH));

    match_enable_d = bus.match_valid && present;
    no_match_d     = bus.match_valid && !present;
    match_index_d  = (bus.match_valid && present) ? port_q[hit_idx] : match_index_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= '0;
      hit_q          <= '0;
      mac_q          <= '{default: '0};
      port_q         <= '{default: '0};
      victim_q       <= '0;
      age_cnt_q      <= '0;
      match_enable_q <= 1'b0;
      no_match_q     <= 1'b0;
      match_index_q  <= '0;
      entry_count_q  <= '0;
      table_full_q   <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      hit_q          <= hit_d;
      mac_q          <= mac_d;
      port_q         <= port_d;
      victim_q       <= victim_d;
      age_cnt_q      <= age_cnt_d;
      match_enable_q <= match_enable_d;
      no_match_q     <= no_match_d;
      match_index_q  <= match_index_d;
      entry_count_q  <= entry_count_d;
      table_full_q   <= table_full_d;
    end
  end

  assign bus.match_enable = match_enable_q;
  assign bus.no_match     = no_match_q;
  assign bus.match_index  = match_index_q;
  assign bus.entry_count  = entry_count_q;
  assign bus.table_full   = table_full_q;
endmodule

// File: tb/tb_mac_address_cam_table.sv
// Directed bench for mac_address_cam_table: one instance with the default aging period
// for functional/full-table/same-cycle/reset checks, one with a 16-cycle period for aging.
module tb_mac_address_cam_table;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  mac_address_cam_table_if #(.NUMBER_OF_PORTS(2), .TABLE_DEPTH(32)) bus ();
  mac_address_cam_table_if #(.NUMBER_OF_PORTS(2), .TABLE_DEPTH(32)) ag ();

  mac_address_cam_table #(.NUMBER_OF_PORTS(2), .TABLE_DEPTH(32), .AGING_PERIOD(32'd1_000_000)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  mac_address_cam_table #(.NUMBER_OF_PORTS(2), .TABLE_DEPTH(32), .AGING_PERIOD(32'd16)) dut_age (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ag.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_bus();
    bus.match_valid = 1'b0;
    bus.write_valid = 1'b0;
    bus.delete_key  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clear_bus();
  endtask

  task automatic lookup(input logic [47:0] k);
    bus.match_valid = 1'b1;
    bus.key = k;
    tick();
  endtask

  task automatic write(input logic [47:0] k, input logic p);
    bus.write_valid = 1'b1;
    bus.write_port = p;
    bus.key = k;
    tick();
  endtask

  task automatic expect_hit(input string tag, input logic [47:0] k, input logic p);
    lookup(k);
    check({tag, "_me"}, 64'(bus.match_enable), 64'd1);
    check({tag, "_nm"}, 64'(bus.no_match), 64'd0);
    check({tag, "_idx"}, 64'(bus.match_index), 64'(p));
  endtask

  task automatic expect_miss(input string tag, input logic [47:0] k);
    lookup(k);
    check({tag, "_nm"}, 64'(bus.no_match), 64'd1);
    check({tag, "_me"}, 64'(bus.match_enable), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    clear_bus();
    bus.key = '0;
    bus.write_port = '0;
    ag.match_valid = 1'b0;
    ag.write_valid = 1'b0;
    ag.delete_key = 1'b0;
    ag.key = '0;
    ag.write_port = '0;
    #2;
    do_reset();

    // Reset state
    check("rst_me", 64'(bus.match_enable), 64'd0);
    check("rst_nm", 64'(bus.no_match), 64'd0);
    check("rst_idx", 64'(bus.match_index), 64'd0);
    check("rst_cnt", 64'(bus.entry_count), 64'd0);
    check("rst_full", 64'(bus.table_full), 64'd0);

    // Lookup on empty table
    expect_miss("empty", 48'h0011_2233_4455);
    check("empty_cnt", 64'(bus.entry_count), 64'd0);

    // Learn then look up
    write(48'hAABB_CCDD_EEFF, 1'b1);
    check("learn_cnt", 64'(bus.entry_count), 64'd1);
    expect_hit("learn", 48'hAABB_CCDD_EEFF, 1'b1);

    // Delete, then confirm it is gone; idle cycle holds match_index
    bus.delete_key = 1'b1;
    bus.key = 48'hAABB_CCDD_EEFF;
    tick();
    check("del_cnt", 64'(bus.entry_count), 64'd0);
    check("hold_idx", 64'(bus.match_index), 64'd1);
    expect_miss("del", 48'hAABB_CCDD_EEFF);

    // Fill entries 0..31 with keys 1..32, port = key[0]
    for (int i = 1; i <= 32; i++) begin
      write(48'(i), 1'(i));
      if (i == 31) begin
        check("fill31_cnt", 64'(bus.entry_count), 64'd31);
        check("fill31_full", 64'(bus.table_full), 64'd0);
      end
    end
    check("full_cnt", 64'(bus.entry_count), 64'd32);
    check("full_flag", 64'(bus.table_full), 64'd1);
    expect_hit("key32", 48'd32, 1'b0);

    // Replacement at victim pointer 0, then 1
    write(48'd33, 1'b1);
    check("repl_cnt", 64'(bus.entry_count), 64'd32);
    expect_miss("key1_gone", 48'd1);
    expect_hit("key33", 48'd33, 1'b1);
    write(48'd34, 1'b0);
    expect_miss("key2_gone", 48'd2);
    expect_hit("key34", 48'd34, 1'b0);
    expect_hit("key3_kept", 48'd3, 1'b1);

    // Reset while a lookup result is pending
    bus.match_valid = 1'b1;
    bus.key = 48'd3;
    #2;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    clear_bus();
    reset_n = 1'b1;
    check("mrst_me", 64'(bus.match_enable), 64'd0);
    check("mrst_nm", 64'(bus.no_match), 64'd0);
    check("mrst_cnt", 64'(bus.entry_count), 64'd0);
    check("mrst_full", 64'(bus.table_full), 64'd0);
    expect_miss("mrst_k3", 48'd3);
    expect_miss("mrst_k34", 48'd34);

    // Delete + write of the same key in one cycle
    write(48'h0000_1234_5678, 1'b0);
    expect_hit("k_p0", 48'h0000_1234_5678, 1'b0);
    bus.delete_key = 1'b1;
    bus.write_valid = 1'b1;
    bus.write_port = 1'b1;
    bus.key = 48'h0000_1234_5678;
    tick();
    check("move_cnt", 64'(bus.entry_count), 64'd1);
    expect_hit("k_p1", 48'h0000_1234_5678, 1'b1);

    // Lookup concurrent with a write of the same new key sees pre-cycle contents
    bus.match_valid = 1'b1;
    bus.write_valid = 1'b1;
    bus.write_port = 1'b0;
    bus.key = 48'h0000_0000_BEEF;
    tick();
    check("conc_nm", 64'(bus.no_match), 64'd1);
    check("conc_me", 64'(bus.match_enable), 64'd0);
    check("conc_cnt", 64'(bus.entry_count), 64'd2);
    expect_hit("conc_next", 48'h0000_0000_BEEF, 1'b0);

    // Aging with a 16-cycle period: ticks at edges 16, 32, 48 after reset release.
    // A is refreshed at edges 10/20/30/40; B is never refreshed and dies at edge 32.
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      if (e == 1) begin
        ag.write_valid = 1'b1; ag.write_port = 1'b1; ag.key = 48'h0000_0000_000A;
      end else if (e == 2) begin
        ag.write_valid = 1'b1; ag.write_port = 1'b0; ag.key = 48'h0000_0000_000B;
      end else if (e % 10 == 0) begin
        ag.match_valid = 1'b1; ag.key = 48'h0000_0000_000A;
      end
      @(posedge clock);
      #1;
      ag.write_valid = 1'b0;
      ag.match_valid = 1'b0;
      if (e % 10 == 0) begin
        check($sformatf("age_refresh_%0d", e), 64'(ag.match_enable), 64'd1);
      end
      if (e == 17) check("age_tick1_cnt", 64'(ag.entry_count), 64'd2);
      if (e == 31) check("age_pre2_cnt", 64'(ag.entry_count), 64'd2);
      if (e == 32) check("age_tick2_cnt", 64'(ag.entry_count), 64'd1);
    end
    ag.match_valid = 1'b1; ag.key = 48'h0000_0000_000B;
    @(posedge clock);
    #1;
    check("age_b_nm", 64'(ag.no_match), 64'd1);
    check("age_b_me", 64'(ag.match_enable), 64'd0);
    ag.key = 48'h0000_0000_000A;
    @(posedge clock);
    #1;
    ag.match_valid = 1'b0;
    check("age_a_me", 64'(ag.match_enable), 64'd1);
    check("age_a_idx", 64'(ag.match_index), 64'd1);
    check("age_cnt", 64'(ag.entry_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
